// File: rtl/main_udiv_seq_14ns_12ns_14_seq.sv
// main_udiv_seq_14ns_12ns_14_seq
//   Iterative restoring radix-2 unsigned divider. It produces one quotient bit
//   per clock and uses valid/ready handshakes on the operand and result sides.
//   It handles one job at a time. A divide by zero keeps the full latency and
//   returns quot = all ones and rem = din0[din1_WIDTH-1:0].
//   Optional feature: define MAIN_UDIV_DIVZERO_FLAG_EN to add the div_zero
//   output. This output is qualified by out_valid.
module main_udiv_seq_14ns_12ns_14_seq #(
   parameter int ID         = 1,
   parameter int din0_WIDTH = 14,
   parameter int din1_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [din0_WIDTH-1:0] quot,
   output logic [din1_WIDTH-1:0] rem,
   output logic                  out_valid,
   input  logic                  out_ready
`ifdef MAIN_UDIV_DIVZERO_FLAG_EN
   ,
   output logic                  div_zero
`endif
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int CW = $clog2(din0_WIDTH + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(din0_WIDTH - 1);

   // The remainder slice of din0 requires the dividend to be at least as wide as the divisor.
   // ID is only an instance tag.
   if (din0_WIDTH < din1_WIDTH || ID < 0) begin : g_bad_cfg
      $error("main_udiv_seq: unsupported parameter set");
   end

   logic [1:0]            state;
   logic [din0_WIDTH-1:0] dividend;
   logic [din1_WIDTH-1:0] divisor;
   logic [din1_WIDTH-1:0] din0_low;
   logic [din1_WIDTH-1:0] pr;
   logic [din0_WIDTH-2:0] qacc;
   logic [CW-1:0]         cnt;
   logic                  dz;

   logic [din1_WIDTH:0]   shifted;
   logic                  qbit;
   logic [din1_WIDTH-1:0] pr_next;
   logic [din0_WIDTH-1:0] q_next;

   // The partial remainder always stays below the divisor, so it is stored in
   // din1_WIDTH bits. The extra bit is needed only in the shifted trial value,
   // and the difference always fits in din1_WIDTH bits.
   // Next-step datapath: shift in the dividend MSB, then trial-subtract.
   always_comb begin
      shifted = {pr, dividend[din0_WIDTH-1]};
      qbit    = (shifted >= {1'b0, divisor});
      pr_next = qbit ? (shifted[din1_WIDTH-1:0] - divisor) : shifted[din1_WIDTH-1:0];
      q_next  = {qacc, qbit};
   end

   assign in_ready = (state == IDLE);

   // Control FSM plus the iteration and result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         dividend  <= '0;
         divisor   <= '0;
         din0_low  <= '0;
         pr        <= '0;
         qacc      <= '0;
         cnt       <= '0;
         dz        <= 1'b0;
         quot      <= '0;
         rem       <= '0;
         out_valid <= 1'b0;
`ifdef MAIN_UDIV_DIVZERO_FLAG_EN
         div_zero  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  dividend <= din0;
                  divisor  <= din1;
                  din0_low <= din0[din1_WIDTH-1:0];
                  pr       <= '0;
                  qacc     <= '0;
                  cnt      <= '0;
                  dz       <= (din1 == '0);
                  state    <= BUSY;
               end
            end
            BUSY: begin
               dividend <= {dividend[din0_WIDTH-2:0], 1'b0};
               pr       <= pr_next;
               qacc     <= q_next[din0_WIDTH-2:0];
               cnt      <= cnt + 1'b1;
               if (cnt == LAST_STEP) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  quot      <= dz ? '1 : q_next;
                  rem       <= dz ? din0_low : pr_next;
`ifdef MAIN_UDIV_DIVZERO_FLAG_EN
                  div_zero  <= dz;
`endif
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
`ifdef MAIN_UDIV_DIVZERO_FLAG_EN
                  div_zero  <= 1'b0;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_main_udiv_seq_14ns_12ns_14_seq.sv
// Scoreboard bench for main_udiv_seq_14ns_12ns_14_seq.
// When an accept is observed, the expected result from a plain-arithmetic
// reference model is pushed into a queue. A monitor pops the queue and
// compares on each result handshake.
module tb_main_udiv_seq_14ns_12ns_14_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [13:0] din0 = '0;
   logic [11:0] din1 = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [13:0] quot;
   logic [11:0] rem;
   logic        out_valid;
   logic        out_ready = 1'b1;
`ifdef MAIN_UDIV_DIVZERO_FLAG_EN
   logic        div_zero;
`endif

   main_udiv_seq_14ns_12ns_14_seq #(.ID(1), .din0_WIDTH(14), .din1_WIDTH(12)) dut (
      .clk(clk), .reset(reset), .din0(din0), .din1(din1),
      .in_valid(in_valid), .in_ready(in_ready),
      .quot(quot), .rem(rem), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MAIN_UDIV_DIVZERO_FLAG_EN
      , .div_zero(div_zero)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned q;
      int unsigned r;
      bit          dz;
   } exp_t;

   exp_t        sb[$];
   int          compared = 0;
   int          mismatched = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   bit          prev_ov = 0;
   int unsigned prev_q = 0;
   int unsigned prev_r = 0;
   bit          rnd_or = 0;

   // Reference model: floor division, with the divide-by-zero result defined
   // as all ones and the low 12 bits of the dividend.
   function automatic exp_t model(input int unsigned a, input int unsigned b);
      exp_t e;
      if (b == 0) begin
         e.q = 16383; e.r = a % 4096; e.dz = 1;
      end else begin
         e.q = a / b; e.r = a % b; e.dz = 0;
      end
      return e;
   endfunction

   task automatic check(input string name, input int unsigned act, input int unsigned req);
      compared++;
      if (act != req) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Random backpressure while the random phase runs.
   always @(posedge clk) if (rnd_or) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
   end

   // Monitor and scoreboard at the inactive edge.
   always @(negedge clk) begin
      if (reset) begin
         sb.delete();
         prev_ov = 0;
      end else begin
         check("in_ready_vs_outstanding", in_ready, (sb.size() == 0));
         if (out_valid) begin
            if (!prev_ov) check("latency", cyc - acc_cyc, 14);
            else begin
               check("hold_quot", quot, prev_q);
               check("hold_rem", rem, prev_r);
            end
         end
         if (in_valid && in_ready) begin
            sb.push_back(model(din0, din1));
            acc_cyc = cyc + 1;
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) check("unexpected_output", 1, 0);
            else begin
               exp_t e;
               e = sb.pop_front();
               check("quot", quot, e.q);
               check("rem", rem, e.r);
`ifdef MAIN_UDIV_DIVZERO_FLAG_EN
               check("div_zero", div_zero, e.dz);
`endif
            end
         end
         prev_ov = out_valid;
         prev_q  = quot;
         prev_r  = rem;
      end
   end

   // Present operands until accepted (bounded), then drop in_valid.
   task automatic send(input logic [13:0] a, input logic [11:0] b);
      int n = 0;
      din0 = a; din1 = b; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk); n++;
      end
      if (!in_ready) check("accept_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      din0 = 14'($urandom); din1 = 12'($urandom);
   endtask

   // Wait until all outstanding results have been consumed (bounded).
   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 400) begin
         @(negedge clk); n++;
      end
      if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_quot", quot, 0);
      check("rst_rem", rem, 0);
`ifdef MAIN_UDIV_DIVZERO_FLAG_EN
      check("rst_div_zero", div_zero, 0);
`endif
      reset = 1'b0;
      @(posedge clk); #1;

      // Directed jobs, including boundaries and divide by zero
      send(14'd100, 12'd7);     drain();
      send(14'd16383, 12'd4095); drain();
      send(14'd16383, 12'd1);   drain();
      send(14'd50, 12'd0);      drain();
      send(14'd0, 12'd1);       drain();

      // Backpressure: hold the result for 10 cycles while garbage in_valid is offered.
      out_ready = 1'b0;
      send(14'd1234, 12'd56);
      n = 0;
      while (!out_valid && n < 100) begin @(negedge clk); n++; end
      check("bp_out_valid_seen", out_valid, 1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; din0 = 14'($urandom); din1 = 12'($urandom);
         check("bp_in_ready_low", in_ready, 0);
         check("bp_out_valid_held", out_valid, 1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_idle_after_ready", in_ready, 1);
      check("bp_out_valid_clear", out_valid, 0);
      drain();

      // Reset during BUSY step 7 aborts the job.
      send(14'd5000, 12'd9);
      repeat (6) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("abort_out_valid", out_valid, 0);
      check("abort_in_ready", in_ready, 1);
      check("abort_quot", quot, 0);
      check("abort_rem", rem, 0);
      @(posedge clk); #1 reset = 1'b0;
      repeat (20) @(negedge clk);
      check("abort_no_output", out_valid, 0);
      @(posedge clk); #1;
      send(14'd9, 12'd3); drain();

      // Random back-to-back jobs under random backpressure
      rnd_or = 1;
      for (int j = 0; j < 1000; j++) begin
         logic [11:0] b;
         b = ($urandom_range(0, 15) == 0) ? 12'd0 :
             ($urandom_range(0, 3) == 0) ? 12'($urandom_range(1, 15)) : 12'($urandom);
         send(14'($urandom), b);
      end
      rnd_or = 0;
      #1 out_ready = 1'b1;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
